// File: rtl/device_mux_6.sv
// device_mux_6: CPU bus decoder/mux steering one master onto six slaves.
// Optional bus-error timeout enabled by macro DEVICE_MUX_BUS_TIMEOUT_EN.
//
// Ports:
//   clk, reset_n       clock, async active-low reset
//   as                 address strobe (bus cycle in progress)
//   master_addr        CPU byte address, bits [23:0] decoded
//   master_write       CPU write data, broadcast to all slaves
//   master_read        read data from the selected slave
//   master_uds/lds     upper/lower byte strobes from the CPU
//   master_ack         transfer acknowledge back to the CPU
//   slaveN_addr        slave-local address (24b for N=1, 8b otherwise)
//   slaveN_write       write data copy
//   slaveN_read        slave read data
//   slaveN_uds/lds     gated byte strobes
//   slaveN_ack         slave acknowledge
//
// Map: addr[23:16]!=IO_PAGE -> slave1 (memory);
//      IO_PAGE, addr[15:8]=00..04 -> slave2..6; 05..FF unmapped.
module device_mux_6 #(
  parameter logic [7:0] IO_PAGE        = 8'hFF,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        as,
  input  logic [31:0] master_addr,
  input  logic [15:0] master_write,
  output logic [15:0] master_read,
  input  logic        master_uds,
  input  logic        master_lds,
  output logic        master_ack,

  output logic [23:0] slave1_addr,
  output logic [15:0] slave1_write,
  input  logic [15:0] slave1_read,
  output logic        slave1_uds,
  output logic        slave1_lds,
  input  logic        slave1_ack,

  output logic [7:0]  slave2_addr,
  output logic [15:0] slave2_write,
  input  logic [15:0] slave2_read,
  output logic        slave2_uds,
  output logic        slave2_lds,
  input  logic        slave2_ack,

  output logic [7:0]  slave3_addr,
  output logic [15:0] slave3_write,
  input  logic [15:0] slave3_read,
  output logic        slave3_uds,
  output logic        slave3_lds,
  input  logic        slave3_ack,

  output logic [7:0]  slave4_addr,
  output logic [15:0] slave4_write,
  input  logic [15:0] slave4_read,
  output logic        slave4_uds,
  output logic        slave4_lds,
  input  logic        slave4_ack,

  output logic [7:0]  slave5_addr,
  output logic [15:0] slave5_write,
  input  logic [15:0] slave5_read,
  output logic        slave5_uds,
  output logic        slave5_lds,
  input  logic        slave5_ack,

  output logic [7:0]  slave6_addr,
  output logic [15:0] slave6_write,
  input  logic [15:0] slave6_read,
  output logic        slave6_uds,
  output logic        slave6_lds,
  input  logic        slave6_ack
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0]  page;
  logic        in_io;
  logic [5:0]  sel;
  logic        bus_act;
  logic [5:0]  ack_vec;
  logic [5:0]  uds_vec;
  logic [5:0]  lds_vec;
  logic        sel_ack;
  logic [15:0] sel_rd;
  logic        tmo_hit;

  assign page  = master_addr[15:8];
  assign in_io = (master_addr[23:16] == IO_PAGE);

  // Reset forces the bus idle, so strobes/ack/data are gated by it too.
  assign bus_act = as & reset_n;

  always_comb begin
    sel = '0;
    unique case (1'b1)
      !in_io:                 sel[0] = 1'b1;
      in_io && page == 8'h00: sel[1] = 1'b1;
      in_io && page == 8'h01: sel[2] = 1'b1;
      in_io && page == 8'h02: sel[3] = 1'b1;
      in_io && page == 8'h03: sel[4] = 1'b1;
      in_io && page == 8'h04: sel[5] = 1'b1;
      default: ;
    endcase
  end

  assign ack_vec = {slave6_ack, slave5_ack, slave4_ack,
                    slave3_ack, slave2_ack, slave1_ack};

  assign uds_vec = {6{master_uds & bus_act}} & sel;
  assign lds_vec = {6{master_lds & bus_act}} & sel;

  assign sel_ack = bus_act & (|(sel & ack_vec));

  always_comb begin
    sel_rd = '0;
    unique case (1'b1)
      sel[0]:  sel_rd = slave1_read;
      sel[1]:  sel_rd = slave2_read;
      sel[2]:  sel_rd = slave3_read;
      sel[3]:  sel_rd = slave4_read;
      sel[4]:  sel_rd = slave5_read;
      sel[5]:  sel_rd = slave6_read;
      default: sel_rd = '0;
    endcase
  end

`ifdef DEVICE_MUX_BUS_TIMEOUT_EN
  logic [7:0] tmo_q;
  logic [7:0] tmo_d;

  // A real ack in the same cycle wins over the bus-error ack.
  assign tmo_hit = bus_act & ~sel_ack & (tmo_q == TMO_LAST);

  always_comb begin
    tmo_d = '0;
    if (bus_act && !master_ack)
      tmo_d = tmo_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      tmo_q <= '0;
    else
      tmo_q <= tmo_d;
  end

  logic unused_tb;
  assign unused_tb = ^{master_addr[31:24]};
`else
  assign tmo_hit = 1'b0;

  logic unused_tb;
  assign unused_tb = ^{master_addr[31:24], clk, TMO_LAST};
`endif

  assign master_ack  = sel_ack | tmo_hit;

  always_comb begin
    master_read = '0;
    unique case (1'b1)
      sel_ack: master_read = sel_rd;
      tmo_hit: master_read = 16'hFFFF;
      default: master_read = '0;
    endcase
  end

  assign slave1_addr = master_addr[23:0];
  assign slave2_addr = master_addr[7:0];
  assign slave3_addr = master_addr[7:0];
  assign slave4_addr = master_addr[7:0];
  assign slave5_addr = master_addr[7:0];
  assign slave6_addr = master_addr[7:0];

  assign slave1_write = master_write;
  assign slave2_write = master_write;
  assign slave3_write = master_write;
  assign slave4_write = master_write;
  assign slave5_write = master_write;
  assign slave6_write = master_write;

  assign slave1_uds = uds_vec[0];
  assign slave2_uds = uds_vec[1];
  assign slave3_uds = uds_vec[2];
  assign slave4_uds = uds_vec[3];
  assign slave5_uds = uds_vec[4];
  assign slave6_uds = uds_vec[5];

  assign slave1_lds = lds_vec[0];
  assign slave2_lds = lds_vec[1];
  assign slave3_lds = lds_vec[2];
  assign slave4_lds = lds_vec[3];
  assign slave5_lds = lds_vec[4];
  assign slave6_lds = lds_vec[5];

endmodule

// File: tb/tb_device_mux_6.sv
// tb_device_mux_6: directed self-checking bench for device_mux_6.
// Timeout checks follow DEVICE_MUX_BUS_TIMEOUT_EN.
module tb_device_mux_6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        as;
  logic [31:0] master_addr;
  logic [15:0] master_write;
  logic [15:0] master_read;
  logic        master_uds, master_lds, master_ack;
  logic [23:0] s1_addr;
  logic [7:0]  s2_addr, s3_addr, s4_addr, s5_addr, s6_addr;
  logic [15:0] s1_w, s2_w, s3_w, s4_w, s5_w, s6_w;
  logic [15:0] s1_r, s2_r, s3_r, s4_r, s5_r, s6_r;
  logic        s1_u, s2_u, s3_u, s4_u, s5_u, s6_u;
  logic        s1_l, s2_l, s3_l, s4_l, s5_l, s6_l;
  logic        s1_a, s2_a, s3_a, s4_a, s5_a, s6_a;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  device_mux_6 dut (
    .clk(clk), .reset_n(reset_n), .as(as),
    .master_addr(master_addr), .master_write(master_write),
    .master_read(master_read), .master_uds(master_uds),
    .master_lds(master_lds), .master_ack(master_ack),
    .slave1_addr(s1_addr), .slave1_write(s1_w), .slave1_read(s1_r),
    .slave1_uds(s1_u), .slave1_lds(s1_l), .slave1_ack(s1_a),
    .slave2_addr(s2_addr), .slave2_write(s2_w), .slave2_read(s2_r),
    .slave2_uds(s2_u), .slave2_lds(s2_l), .slave2_ack(s2_a),
    .slave3_addr(s3_addr), .slave3_write(s3_w), .slave3_read(s3_r),
    .slave3_uds(s3_u), .slave3_lds(s3_l), .slave3_ack(s3_a),
    .slave4_addr(s4_addr), .slave4_write(s4_w), .slave4_read(s4_r),
    .slave4_uds(s4_u), .slave4_lds(s4_l), .slave4_ack(s4_a),
    .slave5_addr(s5_addr), .slave5_write(s5_w), .slave5_read(s5_r),
    .slave5_uds(s5_u), .slave5_lds(s5_l), .slave5_ack(s5_a),
    .slave6_addr(s6_addr), .slave6_write(s6_w), .slave6_read(s6_r),
    .slave6_uds(s6_u), .slave6_lds(s6_l), .slave6_ack(s6_a)
  );

  logic [11:0] strb;
  assign strb = {s6_u, s6_l, s5_u, s5_l, s4_u, s4_l,
                 s3_u, s3_l, s2_u, s2_l, s1_u, s1_l};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_acks(input logic [5:0] a);
    {s6_a, s5_a, s4_a, s3_a, s2_a, s1_a} = a;
  endtask

  // Count acks over n cycles after as rises; return first ack cycle.
  task automatic run_as(input int n, output int first, output int cnt,
                        output logic [15:0] rd);
    first = 0;
    cnt = 0;
    rd = '0;
    @(posedge clk);
    #1 as = 1'b1;
    for (int c = 1; c <= n; c++) begin
      #2;
      if (master_ack) begin
        cnt++;
        if (first == 0) begin
          first = c;
          rd = master_read;
        end
      end
      @(posedge clk);
      #1;
    end
    as = 1'b0;
  endtask

  int first, cnt;
  logic [15:0] rd;

  initial begin
    reset_n = 1'b0;
    as = 1'b1;
    master_addr = 32'h0000_0100;
    master_write = 16'hA55A;
    master_uds = 1'b1;
    master_lds = 1'b1;
    s1_r = 16'h1234; s2_r = 16'h2222; s3_r = 16'h3333;
    s4_r = 16'h4444; s5_r = 16'h5555; s6_r = 16'hBEEF;
    set_acks(6'b000001);
    #12;
    chk("rst_ack", master_ack, 0);
    chk("rst_rd", master_read, 0);
    chk("rst_strb", strb, 0);

    @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk("m1_ack", master_ack, 1);
    chk("m1_rd", master_read, 16'h1234);
    chk("m1_strb", strb, 12'h003);
    chk("m1_addr", s1_addr, 24'h000100);

    master_addr = 32'h00FF_0002;
    master_uds = 1'b0;
    set_acks(6'b000010);
    #1;
    chk("u2_addr", s2_addr, 8'h02);
    chk("u2_strb", strb, 12'h004);
    chk("u2_ack", master_ack, 1);
    chk("u2_rd", master_read, 16'h2222);

    master_addr = 32'h00FF_0400;
    master_uds = 1'b1;
    set_acks(6'b100001);
    #1;
    chk("i6_rd", master_read, 16'hBEEF);
    chk("i6_ack", master_ack, 1);
    chk("i6_strb", strb, 12'hC00);
    set_acks(6'b000001);
    #1;
    chk("i6_noack", master_ack, 0);

    master_addr = 32'h12FF_0100;
    set_acks(6'b000100);
    #1;
    chk("l3_rd", master_read, 16'h3333);
    chk("l3_strb", strb, 12'h030);
    master_addr = 32'h00FF_0233;
    set_acks(6'b001000);
    #1;
    chk("s4_rd", master_read, 16'h4444);
    chk("s4_w", s4_w, 16'hA55A);
    chk("s4_addr", s4_addr, 8'h33);
    master_addr = 32'h00FF_0300;
    set_acks(6'b010000);
    #1;
    chk("t5_rd", master_read, 16'h5555);
    chk("t5_strb", strb, 12'h300);

    master_addr = 32'h00FE_0000;
    set_acks(6'b000001);
    #1;
    chk("fe_strb", strb, 12'h003);
    chk("fe_ack", master_ack, 1);

    master_addr = 32'h00FF_0500;
    set_acks(6'b111111);
    #1;
    chk("um_ack", master_ack, 0);
    chk("um_rd", master_read, 0);
    chk("um_strb", strb, 0);
    master_addr = 32'h00FF_FF00;
    #1;
    chk("umff_ack", master_ack, 0);

    master_addr = 32'h0000_0100;
    as = 1'b0;
    #1;
    chk("as0_ack", master_ack, 0);
    chk("as0_strb", strb, 0);
    chk("as0_rd", master_read, 0);

    as = 1'b1;
    set_acks(6'b000001);
    #1;
    chk("pre_rst_ack", master_ack, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ack", master_ack, 0);
    chk("mid_rst_strb", strb, 0);
    chk("mid_rst_rd", master_read, 0);
    as = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;

    master_addr = 32'h00FF_0500;
    set_acks(6'b000000);
`ifdef DEVICE_MUX_BUS_TIMEOUT_EN
    run_as(100, first, cnt, rd);
    chk("to_first", first, 64);
    chk("to_cnt", cnt, 1);
    chk("to_rd", rd, 16'hFFFF);
    master_addr = 32'h0000_0200;
    run_as(30, first, cnt, rd);
    chk("to_silent", cnt, 0);
    as = 1'b1;
    #1 reset_n = 1'b0;
    #3 reset_n = 1'b1;
    as = 1'b0;
    run_as(70, first, cnt, rd);
    chk("to_after_rst", first, 64);
`else
    run_as(200, first, cnt, rd);
    chk("nto_cnt", cnt, 0);
    master_addr = 32'h0000_0200;
    run_as(200, first, cnt, rd);
    chk("nto_silent", cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
